vcve2_obi_arbiter: RTL and testbench

VCVE2_OBI_ARBITER -- requirements
Module: vcve2_obi_arbiter

---
 rtl/vcve2_obi_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_vcve2_obi_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_obi_arbiter.sv
// Merges the instruction-fetch and LSU OBI requesters onto one shared memory port,
// tracking granted transactions in order. Define VCVE2_OBI_ARB_RR_EN for round-robin arbitration.
module vcve2_obi_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic [2:0]  outstanding_o,
   output logic        spurious_rvalid_o
);

   localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [2:0]  MaxCnt = 3'(MaxOutstanding);
   localparam logic        SrcInstr = 1'b0;
   localparam logic        SrcData  = 1'b1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e            state_r, state_s;
   logic              sel_r, sel_s, pick_s;
   logic              req_s, gnt_s, push_s, pop_s, head_s, avail_s;
   logic              we_r, we_s;
   logic [3:0]        be_r, be_s;
   logic [31:0]       addr_r, addr_s, wdata_r, wdata_s;
   logic              fifo_r [MaxOutstanding];
   logic [PtrW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [2:0]        count_r, count_s;
   logic              spurious_r;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(MaxOutstanding - 1)) begin
         return {PtrW{1'b0}};
      end else begin
         return p + PtrW'(1'b1);
      end
   endfunction

`ifdef VCVE2_OBI_ARB_RR_EN
   logic last_r;

   // Round-robin pick: on contention favour the source not granted most recently
   always_comb begin
      pick_s = SrcInstr;
      if (instr_req_i && data_req_i) begin
         pick_s = ~last_r;
      end else if (data_req_i) begin
         pick_s = SrcData;
      end else begin
         pick_s = SrcInstr;
      end
   end

   // Remember which source took the last grant
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_r <= SrcInstr;
      end else if (gnt_s) begin
         last_r <= sel_s;
      end
   end
`else
   // Fixed priority: the LSU always wins over instruction fetch
   always_comb begin
      pick_s = SrcInstr;
      if (data_req_i) begin
         pick_s = SrcData;
      end else begin
         pick_s = SrcInstr;
      end
   end
`endif

   assign avail_s = (count_r < MaxCnt);

   // Request FSM: select in IDLE, replay latched fields in HOLD until granted
   always_comb begin
      state_s = state_r;
      req_s   = 1'b0;
      sel_s   = sel_r;
      we_s    = 1'b0;
      be_s    = 4'b0000;
      addr_s  = 32'h0000_0000;
      wdata_s = 32'h0000_0000;
      case (state_r)
         IDLE: begin
            if (avail_s && (instr_req_i || data_req_i)) begin
               req_s = 1'b1;
               sel_s = pick_s;
               if (pick_s == SrcData) begin
                  we_s    = data_we_i;
                  be_s    = data_be_i;
                  addr_s  = data_addr_i;
                  wdata_s = data_wdata_i;
               end else begin
                  we_s    = 1'b0;
                  be_s    = 4'b1111;
                  addr_s  = instr_addr_i;
                  wdata_s = 32'h0000_0000;
               end
               state_s = mem_gnt_i ? IDLE : HOLD;
            end else begin
               state_s = IDLE;
            end
         end
         HOLD: begin
            req_s   = 1'b1;
            sel_s   = sel_r;
            we_s    = we_r;
            be_s    = be_r;
            addr_s  = addr_r;
            wdata_s = wdata_r;
            state_s = mem_gnt_i ? IDLE : HOLD;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign gnt_s  = req_s & mem_gnt_i;
   assign push_s = gnt_s;
   assign pop_s  = mem_rvalid_i & (count_r != 3'd0);
   assign head_s = fifo_r[rd_ptr_r];

   // Occupancy update; a simultaneous push and pop leaves the count alone
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 3'd1;
         2'b01:   count_s = count_r - 3'd1;
         default: count_s = count_r;
      endcase
   end

   // State, held request fields, tracking FIFO and sticky spurious flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r    <= IDLE;
         sel_r      <= SrcInstr;
         we_r       <= 1'b0;
         be_r       <= 4'b0000;
         addr_r     <= 32'h0000_0000;
         wdata_r    <= 32'h0000_0000;
         wr_ptr_r   <= {PtrW{1'b0}};
         rd_ptr_r   <= {PtrW{1'b0}};
         count_r    <= 3'd0;
         spurious_r <= 1'b0;
         for (int i = 0; i < int'(MaxOutstanding); i++) begin
            fifo_r[i] <= SrcInstr;
         end
      end else begin
         state_r <= state_s;
         if (req_s) begin
            sel_r   <= sel_s;
            we_r    <= we_s;
            be_r    <= be_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
         end
         if (push_s) begin
            fifo_r[wr_ptr_r] <= sel_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         count_r    <= count_s;
         spurious_r <= spurious_r | (mem_rvalid_i & (count_r == 3'd0));
      end
   end

   assign mem_req_o   = req_s;
   assign mem_we_o    = we_s;
   assign mem_be_o    = be_s;
   assign mem_addr_o  = addr_s;
   assign mem_wdata_o = wdata_s;

   assign instr_gnt_o = gnt_s & (sel_s == SrcInstr);
   assign data_gnt_o  = gnt_s & (sel_s == SrcData);

   assign instr_rvalid_o = pop_s & (head_s == SrcInstr);
   assign data_rvalid_o  = pop_s & (head_s == SrcData);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_err_o     = mem_err_i;

   assign outstanding_o     = count_r;
   assign spurious_rvalid_o = spurious_r;

endmodule

// File: tb/tb_vcve2_obi_arbiter.sv
// Directed self-checking bench for vcve2_obi_arbiter (MaxOutstanding = 2).
// Honours VCVE2_OBI_ARB_RR_EN to select the arbitration scenario.
module tb_vcve2_obi_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req, instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  outstanding;
   logic        spurious;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vcve2_obi_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
      .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
      .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
      .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(outstanding), .spurious_rvalid_o(spurious)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, then inputs may change
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling (well before next edge)
   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      instr_req = 1'b0; instr_addr = 32'h0;
      data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      do_reset();
      settle();
      check("rst_outstanding", 32'(outstanding), 32'd0);
      check("rst_spurious", 32'(spurious), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);

      // Response with nothing outstanding
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      settle();
      check("spur_instr_rvalid", 32'(instr_rvalid), 32'd0);
      check("spur_data_rvalid", 32'(data_rvalid), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      settle();
      check("spur_set", 32'(spurious), 32'd1);
      check("spur_count", 32'(outstanding), 32'd0);
      tick();
      settle();
      check("spur_sticky", 32'(spurious), 32'd1);
      tick();
      do_reset();
      settle();
      check("spur_cleared", 32'(spurious), 32'd0);

`ifdef VCVE2_OBI_ARB_RR_EN
      // Prime with a lone data grant, then contend with responses draining each cycle
      tick();
      data_req = 1'b1; data_addr = 32'h200; mem_gnt = 1'b1;
      settle();
      check("rr_prime_data_gnt", 32'(data_gnt), 32'd1);
      tick();
      instr_req = 1'b1; instr_addr = 32'h100; mem_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("rr_instr_gnt", 32'(instr_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_data_gnt", 32'(data_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
         check("rr_count", 32'(outstanding), 32'd1);
         tick();
      end
      idle_inputs();
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      settle();
      check("rr_drained", 32'(outstanding), 32'd0);
`else
      // Simultaneous requests: data wins, instr follows, responses in order
      tick();
      instr_req = 1'b1; instr_addr = 32'h100;
      data_req = 1'b1; data_addr = 32'h200; data_we = 1'b1; data_be = 4'h3;
      data_wdata = 32'h0000_CAFE; mem_gnt = 1'b1;
      settle();
      check("prio_mem_addr", mem_addr, 32'h200);
      check("prio_data_gnt", 32'(data_gnt), 32'd1);
      check("prio_instr_gnt0", 32'(instr_gnt), 32'd0);
      check("prio_mem_we", 32'(mem_we), 32'd1);
      check("prio_mem_be", 32'(mem_be), 32'h3);
      check("prio_mem_wdata", mem_wdata, 32'h0000_CAFE);
      tick();
      data_req = 1'b0;
      settle();
      check("instr_mem_addr", mem_addr, 32'h100);
      check("instr_gnt", 32'(instr_gnt), 32'd1);
      check("instr_mem_we", 32'(mem_we), 32'd0);
      check("instr_mem_be", 32'(mem_be), 32'hF);
      check("instr_mem_wdata", mem_wdata, 32'h0);
      check("count_one", 32'(outstanding), 32'd1);
      tick();
      mem_gnt = 1'b0;
      settle();
      check("count_full", 32'(outstanding), 32'd2);
      check("full_no_req", 32'(mem_req), 32'd0);
      tick();
      instr_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11;
      settle();
      check("rsp1_data_rvalid", 32'(data_rvalid), 32'd1);
      check("rsp1_instr_rvalid", 32'(instr_rvalid), 32'd0);
      check("rsp1_data_rdata", data_rdata, 32'h11);
      tick();
      mem_rdata = 32'h22; mem_err = 1'b1;
      settle();
      check("rsp2_instr_rvalid", 32'(instr_rvalid), 32'd1);
      check("rsp2_data_rvalid", 32'(data_rvalid), 32'd0);
      check("rsp2_instr_err", 32'(instr_err), 32'd1);
      check("rsp2_instr_rdata", instr_rdata, 32'h22);
      tick();
      idle_inputs();
      settle();
      check("rsp_drained", 32'(outstanding), 32'd0);
      check("rsp_no_spur", 32'(spurious), 32'd0);
`endif

      // Push and pop in the same cycle, then fill to the limit
      tick();
      data_req = 1'b1; data_addr = 32'h300; mem_gnt = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      settle();
      check("pp_data_gnt", 32'(data_gnt), 32'd1);
      check("pp_data_rvalid", 32'(data_rvalid), 32'd1);
      tick();
      mem_rvalid = 1'b0;
      settle();
      check("pp_count_same", 32'(outstanding), 32'd1);
      tick();
      settle();
      check("pp_count_full", 32'(outstanding), 32'd2);
      check("pp_full_no_req", 32'(mem_req), 32'd0);
      tick();
      idle_inputs();
      mem_rvalid = 1'b1;
      tick();
      tick();
      mem_rvalid = 1'b0;
      settle();
      check("pp_drained", 32'(outstanding), 32'd0);

      // Stalled data request must hold address while instr waits
      tick();
      data_req = 1'b1; data_addr = 32'h40;
      settle();
      check("hold_addr_c0", mem_addr, 32'h40);
      tick();
      instr_req = 1'b1; instr_addr = 32'h100;
      settle();
      check("hold_addr_c1", mem_addr, 32'h40);
      check("hold_instr_gnt_c1", 32'(instr_gnt), 32'd0);
      check("hold_req_c1", 32'(mem_req), 32'd1);
      tick();
      data_addr = 32'h99;
      settle();
      check("hold_addr_c2", mem_addr, 32'h40);
      check("hold_instr_gnt_c2", 32'(instr_gnt), 32'd0);
      tick();
      mem_gnt = 1'b1;
      settle();
      check("hold_data_gnt", 32'(data_gnt), 32'd1);
      check("hold_instr_gnt_c3", 32'(instr_gnt), 32'd0);
      check("hold_addr_c3", mem_addr, 32'h40);
      tick();
      data_req = 1'b0;
      settle();
      check("after_hold_instr_gnt", 32'(instr_gnt), 32'd1);
      check("after_hold_addr", mem_addr, 32'h100);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
      settle();
      check("order_data_first", 32'(data_rvalid), 32'd1);
      tick();
      settle();
      check("order_instr_second", 32'(instr_rvalid), 32'd1);
      tick();
      mem_rvalid = 1'b0;

      // Reset while a request is held
      instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
      tick();
      instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h600; mem_gnt = 1'b0;
      tick();
      settle();
      check("rh_in_hold", 32'(mem_req), 32'd1);
      check("rh_count_pre", 32'(outstanding), 32'd1);
      tick();
      rst_n = 1'b0; data_req = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      check("rh_mem_req", 32'(mem_req), 32'd0);
      check("rh_count", 32'(outstanding), 32'd0);
      tick();
      mem_rvalid = 1'b1;
      settle();
      check("rh_late_rvalid", 32'(instr_rvalid), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      settle();
      check("rh_late_spur", 32'(spurious), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
